// File: rtl/axi_slave_mem.sv
// AXI4 slave word memory: independent single-outstanding read and write channels,
// INCR bursts of 32-bit beats, DECERR past the end of the array, plus a backdoor preload port.
module axi_slave_mem #(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [31:0]       bd_data
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int MA_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [IDX_W-1:0] MEM_LIMIT   = IDX_W'(MEM_WORDS);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_DECERR = 2'b11;

    typedef enum logic       {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return idx < MEM_LIMIT;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    logic [31:0] mem [MEM_WORDS];

    r_state_t         r_state_r, r_state_s;
    w_state_t         w_state_r, w_state_s;
    logic [IDX_W-1:0] r_idx_r, w_idx_r, load_idx_s;
    logic [7:0]       r_left_r;
    logic             w_err_r, load_ok_s, beat_err_s;
    logic [31:0]      load_word_s;
    logic             ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
    logic [IDX_W-1:0] ar_idx_s, aw_idx_s, bd_idx_s;
    logic             unused_bits_s;

    assign ar_idx_s = s_araddr[ADDR_W-1:2];
    assign aw_idx_s = s_awaddr[ADDR_W-1:2];
    assign bd_idx_s = bd_addr[ADDR_W-1:2];
    assign unused_bits_s = ^{s_araddr[1:0], s_awaddr[1:0], bd_addr[1:0], s_awlen};

    // Backdoor writes own the array for the cycle, so AXI write data is held off.
    assign s_wready = (w_state_r == W_DATA) && !bd_we;

    assign ar_hs_s = s_arready && s_arvalid;
    assign r_hs_s  = s_rvalid && s_rready;
    assign aw_hs_s = s_awready && s_awvalid;
    assign w_hs_s  = s_wready && s_wvalid;
    assign b_hs_s  = s_bvalid && s_bready;
    assign beat_err_s = w_err_r || !in_range(w_idx_r);

    // Read next-state logic.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s) r_state_s = R_DATA; else r_state_s = R_IDLE;
            R_DATA:  if (r_hs_s && s_rlast) r_state_s = R_IDLE; else r_state_s = R_DATA;
            default: r_state_s = R_IDLE;
        endcase
    end

    // Select the word feeding the next read beat: start address when idle, running index otherwise.
    always_comb begin
        load_idx_s = r_idx_r;
        if (r_state_r == R_IDLE) begin
            load_idx_s = ar_idx_s;
        end else begin
            load_idx_s = r_idx_r;
        end
        load_ok_s = in_range(load_idx_s);
        if (load_ok_s) begin
            load_word_s = mem[load_idx_s[MA_W-1:0]];
        end else begin
            load_word_s = 32'd0;
        end
    end

    // Read state register and registered R-channel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_rdata   <= 32'd0;
            s_rresp   <= 2'b00;
            s_rid     <= '0;
            r_idx_r   <= '0;
            r_left_r  <= 8'd0;
        end else begin
            r_state_r <= r_state_s;
            s_arready <= (r_state_s == R_IDLE);
            if (ar_hs_s) begin
                s_rvalid <= 1'b1;
                s_rid    <= s_arid;
                s_rdata  <= load_word_s;
                s_rresp  <= load_ok_s ? RESP_OKAY : RESP_DECERR;
                s_rlast  <= (s_arlen == 8'd0);
                r_idx_r  <= ar_idx_s + IDX_W'(1);
                r_left_r <= s_arlen;
            end else if (r_hs_s) begin
                if (s_rlast) begin
                    s_rvalid <= 1'b0;
                    s_rlast  <= 1'b0;
                end else begin
                    s_rdata  <= load_word_s;
                    s_rresp  <= load_ok_s ? RESP_OKAY : RESP_DECERR;
                    s_rlast  <= (r_left_r == 8'd1);
                    r_idx_r  <= r_idx_r + IDX_W'(1);
                    r_left_r <= r_left_r - 8'd1;
                end
            end
        end
    end

    // Write next-state logic.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
            W_DATA:  if (w_hs_s && s_wlast) w_state_s = W_RESP; else w_state_s = W_DATA;
            W_RESP:  if (b_hs_s) w_state_s = W_IDLE; else w_state_s = W_RESP;
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write state register, burst index, sticky error and B-channel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            s_awready <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            s_bid     <= '0;
            w_idx_r   <= '0;
            w_err_r   <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            s_awready <= (w_state_s == W_IDLE);
            if (aw_hs_s) begin
                w_idx_r <= aw_idx_s;
                w_err_r <= 1'b0;
                s_bid   <= s_awid;
            end else if (w_hs_s) begin
                w_idx_r <= w_idx_r + IDX_W'(1);
                w_err_r <= beat_err_s;
                if (s_wlast) begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= beat_err_s ? RESP_DECERR : RESP_OKAY;
                end
            end else if (b_hs_s) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bd_we && in_range(bd_idx_s)) begin
            mem[bd_idx_s[MA_W-1:0]] <= bd_data;
        end else if (rst_n && w_hs_s && in_range(w_idx_r)) begin
            mem[w_idx_r[MA_W-1:0]] <= merge_bytes(mem[w_idx_r[MA_W-1:0]], s_wdata, s_wstrb);
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized self-checking bench for axi_slave_mem against a word-array reference model.
module tb_axi_slave_mem;
    localparam int MEM_WORDS = 256;
    localparam int ADDR_W    = 32;
    localparam int ID_W      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic [ID_W-1:0]   s_awid = '0, s_arid = '0, s_bid, s_rid;
    logic [ADDR_W-1:0] s_awaddr = '0, s_araddr = '0, bd_addr = '0;
    logic [7:0]        s_awlen = 8'd0, s_arlen = 8'd0;
    logic              s_awvalid = 1'b0, s_awready, s_arvalid = 1'b0, s_arready;
    logic [31:0]       s_wdata = 32'd0, s_rdata, bd_data = 32'd0;
    logic [3:0]        s_wstrb = 4'd0;
    logic              s_wlast = 1'b0, s_wvalid = 1'b0, s_wready;
    logic [1:0]        s_bresp, s_rresp;
    logic              s_bvalid, s_bready = 1'b0;
    logic              s_rlast, s_rvalid, s_rready = 1'b0;
    logic              bd_we = 1'b0;

    logic [31:0] ref_mem [MEM_WORDS];
    int checks = 0;
    int passed = 0;

    axi_slave_mem #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data)
    );

    task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
        bd_we = 1'b1; bd_addr = addr; bd_data = data;
        if ((addr >> 2) < 32'(MEM_WORDS)) ref_mem[addr >> 2] = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issues one read burst; mode 0: rready always 1, 1: pattern 1,0,0, 2: random.
    task automatic do_read(input logic [31:0] addr, input int len, input logic [ID_W-1:0] id,
                           input int mode, input string tag);
        int cyc, beat;
        bit rr, stalled;
        logic [31:0] idx, exp_data, held;
        logic [1:0] exp_resp;
        s_araddr = addr; s_arlen = 8'(len); s_arid = id; s_arvalid = 1'b1;
        cyc = 0;
        while (!s_arready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        s_arvalid = 1'b0;
        checks++;
        if (s_rvalid !== 1'b1) $display("FAIL %s latency: rvalid=%0b required 1", tag, s_rvalid);
        else passed++;
        beat = 0; cyc = 0; stalled = 0; held = 32'd0;
        while (beat <= len && cyc < 400) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            if (stalled && s_rvalid) begin
                checks++;
                if (s_rdata !== held) $display("FAIL %s hold: rdata=%h required %h", tag, s_rdata, held);
                else passed++;
            end
            if (s_rvalid && rr) begin
                idx = (addr >> 2) + 32'(beat);
                exp_data = (idx < 32'(MEM_WORDS)) ? ref_mem[idx] : 32'd0;
                exp_resp = (idx < 32'(MEM_WORDS)) ? 2'b00 : 2'b11;
                checks++;
                if ({s_rdata, s_rresp, s_rlast, s_rid} !== {exp_data, exp_resp, (beat == len), id})
                    $display("FAIL %s beat%0d: data=%h resp=%b last=%b id=%h required data=%h resp=%b last=%b id=%h",
                             tag, beat, s_rdata, s_rresp, s_rlast, s_rid, exp_data, exp_resp, (beat == len), id);
                else passed++;
                beat++; stalled = 0;
            end else if (s_rvalid) begin
                stalled = 1; held = s_rdata;
            end else begin
                stalled = 0;
            end
            s_rready = rr;
            @(negedge clk);
            cyc++;
        end
        s_rready = 1'b0;
        checks++;
        if (beat <= len) $display("FAIL %s timeout: got %0d beats required %0d", tag, beat, len + 1);
        else if (s_rvalid !== 1'b0) $display("FAIL %s end: rvalid=%0b required 0", tag, s_rvalid);
        else passed++;
    endtask

    // Issues one write burst; clash also fires a backdoor write to the first word alongside beat 0.
    task automatic do_write(input logic [31:0] addr, input int len, input logic [ID_W-1:0] id,
                            input logic [31:0] data0, input logic [3:0] strb0, input bit rnd,
                            input bit clash, input string tag);
        int cyc, beat;
        bit err;
        logic [31:0] idx, d;
        logic [3:0] st;
        s_awaddr = addr; s_awlen = 8'(len); s_awid = id; s_awvalid = 1'b1;
        cyc = 0;
        while (!s_awready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        s_awvalid = 1'b0;
        if (clash) begin
            s_wdata = data0; s_wstrb = strb0; s_wlast = (len == 0); s_wvalid = 1'b1;
            bd_we = 1'b1; bd_addr = addr; bd_data = 32'hCAFE_F00D;
            #1;
            checks++;
            if (s_wready !== 1'b0) $display("FAIL %s bd_prio: wready=%0b required 0", tag, s_wready);
            else passed++;
            if ((addr >> 2) < 32'(MEM_WORDS)) ref_mem[addr >> 2] = 32'hCAFE_F00D;
            @(negedge clk);
            bd_we = 1'b0;
        end
        err = 0; beat = 0; cyc = 0;
        while (beat <= len && cyc < 400) begin
            d  = rnd ? $urandom : data0 + 32'(beat);
            st = rnd ? 4'($urandom) : strb0;
            s_wdata = d; s_wstrb = st; s_wlast = (beat == len); s_wvalid = 1'b1;
            #1;
            if (s_wready) begin
                idx = (addr >> 2) + 32'(beat);
                if (idx < 32'(MEM_WORDS)) begin
                    for (int b = 0; b < 4; b++) if (st[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                end else begin
                    err = 1;
                end
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        cyc = 0;
        while (!s_bvalid && cyc < 50) begin @(negedge clk); cyc++; end
        checks++;
        if ({s_bvalid, s_bid, s_bresp} !== {1'b1, id, err ? 2'b11 : 2'b00})
            $display("FAIL %s bresp: bvalid=%0b bid=%h bresp=%b required 1 %h %b",
                     tag, s_bvalid, s_bid, s_bresp, id, err ? 2'b11 : 2'b00);
        else passed++;
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        checks++;
        if (s_bvalid !== 1'b0) $display("FAIL %s bdone: bvalid=%0b required 0", tag, s_bvalid);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, s_rdata, s_rresp, s_bresp, s_bid, s_rid} !== '0)
            $display("FAIL reset_state: aw=%b ar=%b w=%b b=%b r=%b last=%b rdata=%h rresp=%b bresp=%b bid=%h rid=%h required all 0",
                     s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, s_rdata, s_rresp, s_bresp, s_bid, s_rid);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_awready, s_arready} !== 2'b11) $display("FAIL reset_release: aw=%b ar=%b required 1 1", s_awready, s_arready);
        else passed++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < MEM_WORDS; i++) bd_write(32'(i) << 2, $urandom);
        bd_write(32'h0000_0400, 32'hDEAD_BEEF);
    endtask

    task automatic test_single_read();
        bd_write(32'h80, 32'h2400_006f);
        do_read(32'h80, 0, 4'd3, 0, "single_read");
    endtask

    task automatic test_burst_read();
        bd_write(32'h200, 32'hfe01_0113);
        bd_write(32'h204, 32'h0011_2e23);
        bd_write(32'h208, 32'h0081_2c23);
        bd_write(32'h20C, 32'h0201_0413);
        do_read(32'h200, 3, 4'd7, 0, "burst_read");
        do_read(32'h200, 3, 4'd8, 1, "stall_read");
    endtask

    task automatic test_strobe_write();
        bd_write(32'h40, 32'h1122_3344);
        do_write(32'h40, 0, 4'd2, 32'hAABB_CCDD, 4'b0011, 1'b0, 1'b0, "strobe_write");
        do_read(32'h40, 0, 4'd2, 0, "strobe_readback");
    endtask

    task automatic test_out_of_range();
        do_read(32'h400, 1, 4'd4, 0, "oor_read");
        do_write(32'h3FC, 1, 4'd5, 32'h5555_0000, 4'b1111, 1'b0, 1'b0, "oor_write");
        do_read(32'h3F8, 1, 4'd6, 0, "oor_readback");
    endtask

    task automatic test_backdoor_priority();
        do_write(32'h60, 0, 4'd9, 32'h0000_00AA, 4'b0001, 1'b0, 1'b1, "bd_priority");
        do_read(32'h60, 0, 4'd9, 0, "bd_readback");
    endtask

    task automatic test_reset_mid_burst();
        s_araddr = 32'h200; s_arlen = 8'd3; s_arid = 4'd9; s_arvalid = 1'b1; s_rready = 1'b0;
        @(negedge clk);
        s_arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_rvalid, s_arready} !== 2'b00) $display("FAIL mid_reset: rvalid=%b arready=%b required 0 0", s_rvalid, s_arready);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_arready !== 1'b1) $display("FAIL mid_reset_release: arready=%b required 1", s_arready);
        else passed++;
        do_read(32'h80, 0, 4'd1, 0, "post_reset_read");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 263)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom_range(0, 7), 4'($urandom), 32'd0, 4'd0, 1'b1, 1'b0, "rnd_write");
            else
                do_read(a, $urandom_range(0, 7), 4'($urandom), 2, "rnd_read");
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single_read();
        test_burst_read();
        test_strobe_write();
        test_out_of_range();
        test_backdoor_priority();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
